affine_mv_scheduler: RTL
========================

AFFINE_MV_SCHEDULER -- requirements
Module: affine_mv_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the signed width of coordinates and motion vectors; it SHALL match the affine datapath WIDTH.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_S  in  4  scale code, forwarded to the datapath.
- job_log2n  in  2  grid of (1<<job_log2n) x (1<<job_log2n) 4x4 sub-blocks.
- job_mv0_h, job_mv1_h, job_mv0_v, job_mv1_v  in  WIDTH each  signed control-point MVs.
- dp_S  out  4  datapath scale code.
- dp_x, dp_y  out  WIDTH each  datapath sub-block coordinate.
- dp_mv0_h, dp_mv1_h, dp_mv0_v, dp_mv1_v  out  WIDTH each  datapath MVs.
- dp_mv_h, dp_mv_v  in  WIDTH each  datapath results.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_mv_h, out_mv_v  out  WIDTH each  FIFO head result.
- out_idx  out  6  raster index of the head result.
- out_last  out  1  head is the final result of the job.
- done  out  1  one-cycle pulse at job end.

Function
REQ-003 The block SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-004 A job SHALL be accepted in the cycle where job_valid && job_ready; job_S, job_log2n and the four MVs SHALL be latched, and the FSM SHALL move IDLE->ISSUE.
REQ-005 In all states, dp_S and dp_mv* SHALL be driven from the latched job registers and held constant for the whole job.
REQ-006 Issue order SHALL be raster: ix inner, iy outer, both 0..N-1 where N = 1<<log2n; dp_x = 4*ix and dp_y = 4*iy, both combinational from the counters.
REQ-007 An issue SHALL occur in an ISSUE cycle only when fifo_count + inflight < 4, where inflight is the number of set bits in a 2-stage valid shift register; an issue shifts a 1 into that register, otherwise a 0 is shifted in.
REQ-008 Datapath latency SHALL be 2 cycles: a coordinate issued in cycle t produces a result on dp_mv_h/dp_mv_v in cycle t+2, which is pushed to the FIFO at the end of t+2, together with its idx (iy*N+ix) and last flag.
REQ-009 After the issue of index N*N-1, the FSM SHALL move ISSUE->DRAIN.
REQ-010 DRAIN->IDLE SHALL occur when inflight==0, the FIFO is empty and no pop is pending; done SHALL pulse high in the same cycle as this transition.
REQ-011 The result FIFO SHALL be 4 entries deep, first-word fall-through; out_valid = (fifo_count != 0), and a pop occurs on out_valid && out_ready.
REQ-012 A simultaneous push and pop SHALL leave fifo_count unchanged; a push into a full FIFO is impossible under REQ-007 and SHALL be asserted against by the bench.
REQ-013 With out_ready held high the block SHALL sustain one issue per cycle; job accepted in cycle 0 gives the first issue in cycle 1, the first out_valid in cycle 4, and the last out_valid in cycle N*N+3.
REQ-014 job_valid SHALL be ignored outside IDLE.

Reset
REQ-015 When rst is high at a clock edge, the FSM SHALL enter IDLE and the counters, valid shift register and FIFO pointers/count SHALL clear; this applies mid-job, and in-flight results are discarded.
REQ-016 Values after reset: job_ready=1, out_valid=0, out_last=0, done=0, dp_x=dp_y=0, latched job registers=0, and perf_stall_cnt=0 when present.

Configuration
REQ-017 With AFFINE_SCHED_PERF_EN defined, the block SHALL add output port perf_stall_cnt (16 bits).
- It counts ISSUE cycles in which the credit check of REQ-007 blocks an issue.
- It saturates at 0xFFFF and clears only on rst.
REQ-018 With AFFINE_SCHED_PERF_EN undefined, the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- V1: log2n=1, mv0=(0,0), mv1=(16,0), S=0, out_ready=1 -> 4 results, idx 0,1,2,3 in order; out_last on idx 3; results match the golden datapath model; done pulses at cycle 8.
- V2: log2n=2, out_ready=1 -> 16 results in cycles 4..19 with no gaps; perf_stall_cnt=0.
- V3: log2n=2, out_ready=0 for the first 10 cycles -> issues stop once fifo_count+inflight=4; no result is lost or duplicated; perf_stall_cnt equals the blocked ISSUE cycles.
- V4: job_valid held high throughout -> the second job is accepted only in the cycle after done; job_ready=0 in between.
- V5: rst asserted in cycle 6 of a log2n=2 job -> next cycle out_valid=0, job_ready=1, FIFO empty; a following log2n=0 job yields exactly one result with idx 0 and out_last=1.
- V6: out_ready toggled every cycle with log2n=3 -> all 64 idx values arrive in order; out_last only on idx 63.

Source files
------------

// File: rtl/affine_mv_scheduler.sv
// Affine MV sub-block scheduler: issues raster coordinates to a 2-cycle datapath and
// buffers results in a 4-deep FWFT FIFO. Optional stall counter under AFFINE_SCHED_PERF_EN.
module affine_mv_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [3:0]              job_S,
  input  logic [1:0]              job_log2n,
  input  logic signed [WIDTH-1:0] job_mv0_h,
  input  logic signed [WIDTH-1:0] job_mv1_h,
  input  logic signed [WIDTH-1:0] job_mv0_v,
  input  logic signed [WIDTH-1:0] job_mv1_v,
  output logic [3:0]              dp_S,
  output logic signed [WIDTH-1:0] dp_x,
  output logic signed [WIDTH-1:0] dp_y,
  output logic signed [WIDTH-1:0] dp_mv0_h,
  output logic signed [WIDTH-1:0] dp_mv1_h,
  output logic signed [WIDTH-1:0] dp_mv0_v,
  output logic signed [WIDTH-1:0] dp_mv1_v,
  input  logic signed [WIDTH-1:0] dp_mv_h,
  input  logic signed [WIDTH-1:0] dp_mv_v,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_mv_h,
  output logic signed [WIDTH-1:0] out_mv_v,
  output logic [5:0]              out_idx,
  output logic                    out_last,
  output logic                    done
`ifdef AFFINE_SCHED_PERF_EN
  ,
  output logic [15:0]             perf_stall_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [3:0]       s_q;
  logic [1:0]       log2n_q;
  logic [WIDTH-1:0] mv0h_q, mv1h_q, mv0v_q, mv1v_q;
  logic [2:0]       ix, iy, nmax;
  logic [1:0]       vsr;
  logic [5:0]       idx_p0, idx_p1, issue_idx;
  logic             last_p0, last_p1;

  logic [WIDTH-1:0] fifo_h    [4];
  logic [WIDTH-1:0] fifo_v    [4];
  logic [5:0]       fifo_idx  [4];
  logic             fifo_last [4];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       fifo_count;

  logic [2:0]       inflight;
  logic             credit_ok, issue, last_issue, push, pop;

  always_comb begin
    case (log2n_q)
      2'd0:    nmax = 3'd0;
      2'd1:    nmax = 3'd1;
      2'd2:    nmax = 3'd3;
      default: nmax = 3'd7;
    endcase
  end

  // Credit covers both buffered results and those still in the datapath pipe.
  assign inflight   = {2'b00, vsr[0]} + {2'b00, vsr[1]};
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < 4'd4;
  assign issue      = (state == ISSUE) && credit_ok;
  assign last_issue = (ix == nmax) && (iy == nmax);
  assign issue_idx  = ({3'b000, iy} << log2n_q) | {3'b000, ix};
  assign push       = vsr[1];
  assign pop        = out_valid && out_ready;

  assign job_ready  = (state == IDLE);
  assign done       = (state == DRAIN) && (inflight == 3'd0) && (fifo_count == 3'd0);

  assign dp_S     = s_q;
  assign dp_mv0_h = mv0h_q;
  assign dp_mv1_h = mv1h_q;
  assign dp_mv0_v = mv0v_q;
  assign dp_mv1_v = mv1v_q;
  assign dp_x     = {{(WIDTH-5){1'b0}}, ix, 2'b00};
  assign dp_y     = {{(WIDTH-5){1'b0}}, iy, 2'b00};

  assign out_valid = (fifo_count != 3'd0);
  assign out_mv_h  = fifo_h[rd_ptr];
  assign out_mv_v  = fifo_v[rd_ptr];
  assign out_idx   = fifo_idx[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s_q        <= '0;
      log2n_q    <= '0;
      mv0h_q     <= '0;
      mv1h_q     <= '0;
      mv0v_q     <= '0;
      mv1v_q     <= '0;
      ix         <= '0;
      iy         <= '0;
      vsr        <= '0;
      idx_p0     <= '0;
      idx_p1     <= '0;
      last_p0    <= 1'b0;
      last_p1    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            s_q     <= job_S;
            log2n_q <= job_log2n;
            mv0h_q  <= job_mv0_h;
            mv1h_q  <= job_mv1_h;
            mv0v_q  <= job_mv0_v;
            mv1v_q  <= job_mv1_v;
            ix      <= '0;
            iy      <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (last_issue) begin
              ix    <= '0;
              iy    <= '0;
              state <= DRAIN;
            end else if (ix == nmax) begin
              ix <= '0;
              iy <= iy + 3'd1;
            end else begin
              ix <= ix + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // idx/last ride alongside the datapath so they meet its result at push time.
      vsr     <= {vsr[0], issue};
      idx_p0  <= issue_idx;
      last_p0 <= last_issue;
      idx_p1  <= idx_p0;
      last_p1 <= last_p0;

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      fifo_count <= fifo_count + 3'd1;
      else if (pop && !push) fifo_count <= fifo_count - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_h[wr_ptr]    <= dp_mv_h;
      fifo_v[wr_ptr]    <= dp_mv_v;
      fifo_idx[wr_ptr]  <= idx_p1;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

`ifdef AFFINE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if ((state == ISSUE) && !credit_ok && (perf_stall_cnt != 16'hFFFF))
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif

endmodule
